// File: rtl/com_bus_scheduler.sv
// Common-bus ownership scheduler: snoop > mem > proc with per-class round-robin,
// one RELEASE turnaround between grants. Define COM_BUS_TIMEOUT_EN for the hold watchdog.
module com_bus_scheduler #(
  parameter int unsigned N_PROC  = 8,
  parameter int unsigned N_SNOOP = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PROC-1:0]  Com_Bus_Req_proc,
  input  logic [N_SNOOP-1:0] Com_Bus_Req_snoop,
  input  logic               Mem_snoop_req,
  output logic [N_PROC-1:0]  Com_Bus_Gnt_proc,
  output logic [N_SNOOP-1:0] Com_Bus_Gnt_snoop,
  output logic               Mem_snoop_gnt,
  output logic               Bus_busy,
  output logic [4:0]         Owner_id,
  output logic               Timeout_err
);

  localparam int unsigned PPW = (N_PROC  > 1) ? $clog2(N_PROC)  : 1;
  localparam int unsigned SPW = (N_SNOOP > 1) ? $clog2(N_SNOOP) : 1;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("com_bus_scheduler: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t             state, state_n;
  logic [PPW-1:0]     ptr_proc, ptr_proc_n;
  logic [SPW-1:0]     ptr_snoop, ptr_snoop_n;
  logic [N_PROC-1:0]  gnt_proc_n;
  logic [N_SNOOP-1:0] gnt_snoop_n;
  logic               gnt_mem_n;
  logic [4:0]         owner_n;
  logic               owner_req;

  logic               p_hit, s_hit;
  int unsigned        p_win, s_win, p_best, s_best, p_dist, s_dist;

`ifdef COM_BUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] wd_cnt, wd_cnt_n;
  logic          err_q, err_n;
  assign Timeout_err = err_q;
`else
  assign Timeout_err = 1'b0;
`endif

  assign Bus_busy  = (|Com_Bus_Gnt_proc) | (|Com_Bus_Gnt_snoop) | Mem_snoop_gnt;
  assign owner_req = (|(Com_Bus_Gnt_proc & Com_Bus_Req_proc))
                   | (|(Com_Bus_Gnt_snoop & Com_Bus_Req_snoop))
                   | (Mem_snoop_gnt & Mem_snoop_req);

  // Round-robin: winner is the requester at the smallest wrapped distance from the pointer.
  always_comb begin
    p_best = N_PROC;
    p_win  = 0;
    p_dist = 0;
    for (int unsigned i = 0; i < N_PROC; i++) begin
      if (Com_Bus_Req_proc[i]) begin
        p_dist = (i + N_PROC - 32'(ptr_proc)) % N_PROC;
        if (p_dist < p_best) begin
          p_best = p_dist;
          p_win  = i;
        end
      end
    end
    p_hit = (p_best < N_PROC);
  end

  always_comb begin
    s_best = N_SNOOP;
    s_win  = 0;
    s_dist = 0;
    for (int unsigned i = 0; i < N_SNOOP; i++) begin
      if (Com_Bus_Req_snoop[i]) begin
        s_dist = (i + N_SNOOP - 32'(ptr_snoop)) % N_SNOOP;
        if (s_dist < s_best) begin
          s_best = s_dist;
          s_win  = i;
        end
      end
    end
    s_hit = (s_best < N_SNOOP);
  end

  always_comb begin
    state_n     = state;
    gnt_proc_n  = Com_Bus_Gnt_proc;
    gnt_snoop_n = Com_Bus_Gnt_snoop;
    gnt_mem_n   = Mem_snoop_gnt;
    owner_n     = Owner_id;
    ptr_proc_n  = ptr_proc;
    ptr_snoop_n = ptr_snoop;
`ifdef COM_BUS_TIMEOUT_EN
    wd_cnt_n    = wd_cnt;
    err_n       = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef COM_BUS_TIMEOUT_EN
        wd_cnt_n = '0;
`endif
        if (s_hit) begin
          gnt_snoop_n = N_SNOOP'(1) << s_win;
          owner_n     = {2'd1, 3'(s_win)};
          ptr_snoop_n = SPW'((s_win + 1) % N_SNOOP);
          state_n     = GRANT;
        end else if (Mem_snoop_req) begin
          gnt_mem_n = 1'b1;
          owner_n   = {2'd2, 3'd0};
          state_n   = GRANT;
        end else if (p_hit) begin
          gnt_proc_n = N_PROC'(1) << p_win;
          owner_n    = {2'd0, 3'(p_win)};
          ptr_proc_n = PPW'((p_win + 1) % N_PROC);
          state_n    = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          gnt_proc_n  = '0;
          gnt_snoop_n = '0;
          gnt_mem_n   = 1'b0;
          owner_n     = '0;
          state_n     = RELEASE;
        end
`ifdef COM_BUS_TIMEOUT_EN
        // Grant stays visible for exactly TIMEOUT cycles before the revoke edge.
        else if (wd_cnt == CW'(TIMEOUT - 1)) begin
          gnt_proc_n  = '0;
          gnt_snoop_n = '0;
          gnt_mem_n   = 1'b0;
          owner_n     = '0;
          err_n       = 1'b1;
          state_n     = RELEASE;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
`endif
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      Com_Bus_Gnt_proc  <= '0;
      Com_Bus_Gnt_snoop <= '0;
      Mem_snoop_gnt     <= 1'b0;
      Owner_id          <= '0;
      ptr_proc          <= '0;
      ptr_snoop         <= '0;
`ifdef COM_BUS_TIMEOUT_EN
      wd_cnt            <= '0;
      err_q             <= 1'b0;
`endif
    end else begin
      state             <= state_n;
      Com_Bus_Gnt_proc  <= gnt_proc_n;
      Com_Bus_Gnt_snoop <= gnt_snoop_n;
      Mem_snoop_gnt     <= gnt_mem_n;
      Owner_id          <= owner_n;
      ptr_proc          <= ptr_proc_n;
      ptr_snoop         <= ptr_snoop_n;
`ifdef COM_BUS_TIMEOUT_EN
      wd_cnt            <= wd_cnt_n;
      err_q             <= err_n;
`endif
    end
  end

endmodule

// File: doc/com_bus_scheduler.md
# com_bus_scheduler

Sequences ownership of the shared common bus between the data caches' processor-side request ports, their snoop-side ports and the memory write-back path. It grants exactly one owner at a time and holds the grant while the owner keeps requesting. Owners are picked by fixed class priority, with round-robin inside each class. An optional watchdog revokes grants held too long. It sits between the per-processor cache wrappers and the common bus / memory controller.

## Interface
Parameters:
- N_PROC, 8, number of processor-side requesters
- N_SNOOP, 4, number of snoop-side requesters
- TIMEOUT, 64, maximum grant hold in cycles (watchdog only); must be ≥ 2

Ports:
- clk  input  1  bus clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- Com_Bus_Req_proc  input  N_PROC  processor-side bus requests, bit i = cache i
- Com_Bus_Req_snoop  input  N_SNOOP  snoop-side bus requests
- Mem_snoop_req  input  1  memory controller requests bus for write-back
- Com_Bus_Gnt_proc  output  N_PROC  one-hot-or-zero processor grants
- Com_Bus_Gnt_snoop  output  N_SNOOP  one-hot-or-zero snoop grants
- Mem_snoop_gnt  output  1  memory grant
- Bus_busy  output  1  high while any grant is asserted
- Owner_id  output  5  {class[1:0], index[2:0]}; class 0 = proc, 1 = snoop, 2 = mem; 0 when idle
- Timeout_err  output  1  one-cycle pulse on watchdog revoke

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: evaluate the requests.
  - Priority order: snoop > mem > proc.
  - Snoop and proc classes each keep a round-robin pointer. The search starts at the pointer and wraps modulo class size.
  - If any request is present: register the grant and go to GRANT.
  - If none: stay in IDLE.
- GRANT: hold the grant while the owner's request bit stays high.
  - When the owner's request is low at a rising edge: drop all grants and go to RELEASE.
  - The class pointer becomes winner index + 1, mod class size. It is updated on the grant edge.
- RELEASE: exactly one turnaround cycle with all grants low, then IDLE. Requests seen during RELEASE are ignored.
- Outputs are mutually exclusive at all times. At most one bit across Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop and Mem_snoop_gnt is high.
- Bus_busy = OR of all grants. Owner_id is registered together with the grant.
- Higher-priority requests arriving during GRANT do not preempt. They win at the next IDLE evaluation.
- Reset (at any time, including mid-grant):
  - All grants, Bus_busy, Owner_id and Timeout_err go to 0.
  - Both pointers go to 0 and the state to IDLE, immediately (asynchronous).
  - First arbitration happens at the first rising edge after rst_n deasserts.

## Timing
- Grant latency: a request sampled in IDLE at edge k gives the grant visible after edge k (one cycle from the request assertion edge).
- Release: the owner drops its request before edge m. Grants fall after edge m. RELEASE occupies the cycle after m. The next grant is visible after edge m+2 at the earliest.
- Minimum grant length: 1 cycle. A requester deasserting in the same cycle its grant appears gets a 1-cycle grant.
- Back-to-back from the same requester: at least one RELEASE cycle between grants.
- Watchdog: a counter clears on entry to GRANT and increments each GRANT cycle.
  - On reaching TIMEOUT: grants fall, Timeout_err pulses for 1 cycle, go to RELEASE, pointer advances past the owner.
  - A request still held afterwards is re-arbitrated normally.

## Configuration
- COM_BUS_TIMEOUT_EN defined: the watchdog counter and Timeout_err behave as above.
- Not defined: no counter is synthesised, grants are held indefinitely, and Timeout_err is tied to 0.

## Test plan
- Reset mid-grant: Com_Bus_Req_proc=8'h01, pull rst_n low while proc 0 holds the grant -> all grants 0 immediately. After release, proc 0 is regranted one edge later with Owner_id=5'h00.
- Round-robin: Com_Bus_Req_proc=8'hFF, each owner holds 2 cycles then drops for 2 cycles -> grant order 0,1,...,7,0. A RELEASE cycle separates every grant.
- Priority: Com_Bus_Req_proc=8'h04, Mem_snoop_req=1 and Com_Bus_Req_snoop=4'h2 all in IDLE -> snoop 1 (Owner_id=5'h09), then mem (5'h10), then proc 2 (5'h02).
- No preemption: proc 3 holds the grant, snoop 0 requests -> proc 3 keeps the grant until its request drops. Snoop 0 is granted 2 edges after the drop.
- Watchdog (COM_BUS_TIMEOUT_EN, TIMEOUT=64): proc 5 holds its request 100 cycles, proc 6 also requesting -> grant revoked after 64 cycles, Timeout_err pulses once, proc 6 is granted next.
- Invariant: random requests for 10k cycles -> at most one grant high per cycle, Bus_busy == OR(grants), no grant is issued in the cycle right after any grant falls.
